adsr_envelope: RTL

// - Downstream stage of the sample player. Shapes the player's 16-bit signed sample stream with an

---
 rtl/adsr_envelope.sv | 96 +++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven ADSR envelope stepped every TICK_DIV clocks, applied to a signed sample stream
module adsr_envelope #(
    parameter int TICK_DIV = 256,
    parameter int ENV_BITS = 16
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                gate,
    input  logic [ENV_BITS-1:0] attack_rate,
    input  logic [ENV_BITS-1:0] decay_rate,
    input  logic [ENV_BITS-1:0] sustain_level,
    input  logic [ENV_BITS-1:0] release_rate,
    input  logic [15:0]         sample_in,
    input  logic                sample_in_valid,
    output logic [15:0]         sample_out,
    output logic                sample_out_valid,
    output logic [ENV_BITS-1:0] env_level,
    output logic                active
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ENV_BITS:0] MAX = {1'b0, {ENV_BITS{1'b1}}};
    localparam int PW = 16 + ENV_BITS + 1;

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [ENV_BITS-1:0] level_q, level_d;
    logic [CW-1:0]       cnt_q;
    logic                gate_q, vld_q;
    logic [15:0]         out_q;
    logic                tick, rise, fall;
    logic [ENV_BITS:0]   lvl_x, att_sum, dec_lim;
    logic [PW-1:0]       s_x, e_x, prod;

    assign tick    = cnt_q == CW'(TICK_DIV - 1);
    assign rise    = gate & ~gate_q;
    assign fall    = ~gate & gate_q;
    assign lvl_x   = {1'b0, level_q};
    assign att_sum = lvl_x + {1'b0, attack_rate};
    // level - decay <= sustain, rearranged so nothing can go negative
    assign dec_lim = {1'b0, sustain_level} + {1'b0, decay_rate};
    assign s_x     = {{(ENV_BITS + 1){sample_in[15]}}, sample_in};
    assign e_x     = {17'b0, level_q};
    assign prod    = s_x * e_x;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise)
            state_d = ATTACK;
        else if (fall)
            state_d = (state_q == IDLE || state_q == RELEASE) ? state_q : RELEASE;
        else if (tick) begin
            case (state_q)
                ATTACK: begin
                    level_d = (attack_rate == '0 || att_sum >= MAX) ? '1 : att_sum[ENV_BITS-1:0];
                    state_d = (attack_rate == '0 || att_sum >= MAX) ? DECAY : ATTACK;
                end
                DECAY: begin
                    level_d = (decay_rate == '0 || lvl_x <= dec_lim) ? sustain_level : level_q - decay_rate;
                    state_d = (decay_rate == '0 || lvl_x <= dec_lim) ? SUSTAIN : DECAY;
                end
                SUSTAIN: level_d = sustain_level;
                RELEASE: begin
                    level_d = (release_rate == '0 || level_q <= release_rate) ? '0 : level_q - release_rate;
                    state_d = (release_rate == '0 || level_q <= release_rate) ? IDLE : RELEASE;
                end
                default: level_d = '0;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            vld_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            gate_q  <= gate;
            vld_q   <= sample_in_valid;
            if (sample_in_valid)
                out_q <= prod[ENV_BITS+15:ENV_BITS];
        end
    end

    assign sample_out       = out_q;
    assign sample_out_valid = vld_q;
    assign env_level        = level_q;
    assign active           = state_q != IDLE;
endmodule
